uart_tx_fifo: RTL and testbench

//  Buffered 8N1/8N2 UART transmitter. CPU-side write port pushes bytes into an on-chip FIFO;
//  a serialiser drains it onto the tx line at a fixed baud, gated by hardware flow control (cts_n).

---
 rtl/uart_tx_fifo.sv | 168 ++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1/8N2 UART transmitter: CPU write port -> FIFO -> serialiser,
// with frame starts gated by a synchronised clear-to-send.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_AW      = 4,
    parameter int STOP_BITS    = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [7:0]         wr_data,
    input  logic               cts_n,
    output logic               tx,
    output logic               busy,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               overflow
);

    localparam int DEPTH = 2 ** FIFO_AW;
    localparam int TW    = 17;
    localparam logic [TW-1:0]      BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0]      STOP_RELOAD = TW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [FIFO_AW:0]   DEPTH_CNT   = (FIFO_AW + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wr_ptr_q;
    logic [FIFO_AW-1:0]  rd_ptr_q;
    logic [FIFO_AW:0]    count_q;
    logic [FIFO_AW:0]    count_d;
    logic                overflow_q;
    logic                cts_meta_q;
    logic                cts_s_q;
    state_t              state_q;
    logic [TW-1:0]       timer_q;
    logic [2:0]          bit_idx_q;
    logic [7:0]          shift_q;
    logic                tx_q;
    logic                busy_q;
    logic                push;
    logic                pop;
    logic                can_start;
    logic                timer_done;

    // full is judged on the pre-edge occupancy, so a pop in the same cycle
    // never rescues a write that arrives while full.
    assign full       = (count_q == DEPTH_CNT);
    assign empty      = (count_q == '0);
    assign push       = wr_en && !full;
    assign can_start  = !empty && !cts_s_q;
    assign timer_done = (timer_q == '0);
    assign pop        = can_start && ((state_q == IDLE) || (state_q == STOP && timer_done));

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q    <= count_d;
            overflow_q <= wr_en && full;
        end
    end

    // cts_n is asynchronous to clk; resetting to "not clear" keeps the line quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            cts_meta_q <= 1'b1;
            cts_s_q    <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_s_q    <= cts_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        shift_q <= mem[rd_ptr_q];
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        timer_q <= BIT_RELOAD;
                        state_q <= START;
                    end
                end
                START: begin
                    if (timer_done) begin
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                        timer_q   <= BIT_RELOAD;
                        state_q   <= DATA;
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                DATA: begin
                    if (timer_done) begin
                        if (bit_idx_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            timer_q <= STOP_RELOAD;
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            shift_q   <= shift_q >> 1;
                            tx_q      <= shift_q[1];
                            timer_q   <= BIT_RELOAD;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                STOP: begin
                    // Chaining straight into START keeps back-to-back frames gap-free.
                    if (timer_done) begin
                        if (pop) begin
                            shift_q <= mem[rd_ptr_q];
                            tx_q    <= 1'b0;
                            timer_q <= BIT_RELOAD;
                            state_q <= START;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tx       = tx_q;
    assign busy     = busy_q;
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes queue expected bytes, per-instance
// monitors decode the tx line frame by frame and compare against the queue.
module tb_uart_tx_fifo;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rst_seen = 1'b1;
    int         cyc = 0;

    logic       wr_en1 = 1'b0, wr_en2 = 1'b0;
    logic [7:0] wr_data1 = '0, wr_data2 = '0;
    logic       cts_n1 = 1'b0, cts_n2 = 1'b0;
    logic       tx1, busy1, full1, empty1, overflow1;
    logic       tx2, busy2, full2, empty2, overflow2;
    logic [4:0] count1, count2;

    logic [7:0] exp1_q[$];
    logic [7:0] exp2_q[$];
    int         starts_q[$];
    int         n_checks = 0;
    int         n_pass = 0;
    int         last_wr_cyc = 0;

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en1), .wr_data(wr_data1), .cts_n(cts_n1),
        .tx(tx1), .busy(busy1), .full(full1), .empty(empty1), .count(count1),
        .overflow(overflow1)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_AW(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .wr_en(wr_en2), .wr_data(wr_data2), .cts_n(cts_n2),
        .tx(tx2), .busy(busy2), .full(full2), .empty(empty2), .count(count2),
        .overflow(overflow2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rst_seen <= rst;
    end

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
                     expected, expected);
        end
    endtask

    function automatic logic txv(input int w);
        return (w == 0) ? tx1 : tx2;
    endfunction

    function automatic logic busyv(input int w);
        return (w == 0) ? busy1 : busy2;
    endfunction

    function automatic logic emptyv(input int w);
        return (w == 0) ? empty1 : empty2;
    endfunction

    // Called at a negedge; drives one write, returns at the next negedge.
    task automatic wr(input int w, input logic [7:0] d, input bit acc);
        if (w == 0) begin
            wr_en1 = 1'b1; wr_data1 = d;
            if (acc) exp1_q.push_back(d);
        end else begin
            wr_en2 = 1'b1; wr_data2 = d;
            if (acc) exp2_q.push_back(d);
        end
        @(negedge clk);
        wr_en1 = 1'b0;
        wr_en2 = 1'b0;
        last_wr_cyc = cyc;
        $display("[%0d] dut%0d write 0x%02h accept_expected=%0d", cyc, w + 1, d, acc);
    endtask

    task automatic run_until_idle(input int w, input int limit, output int nbusy);
        bit done;
        nbusy = 0;
        done  = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (busyv(w)) nbusy++;
            else if (emptyv(w)) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check("idle_timeout", 0, 1);
    endtask

    task automatic monitor(input int w);
        int         sb;
        int         slot;
        logic       v;
        logic [7:0] data;
        logic [7:0] e;
        bit         bad;
        bit         abort;
        sb = (w == 0) ? 1 : 2;
        forever begin
            @(negedge clk);
            if (!rst_seen && txv(w) === 1'b0) begin
                if (w == 0) starts_q.push_back(cyc);
                bad   = 1'b0;
                abort = 1'b0;
                data  = '0;
                for (int t = 0; t < (9 + sb) * CPB; t++) begin
                    if (t > 0) @(negedge clk);
                    if (rst_seen) begin
                        abort = 1'b1;
                        break;
                    end
                    v    = txv(w);
                    slot = t / CPB;
                    if (slot == 0) begin
                        if (v !== 1'b0) bad = 1'b1;
                    end else if (slot <= 8) begin
                        if (t % CPB == 0) data[slot-1] = v;
                        else if (v !== data[slot-1]) bad = 1'b1;
                    end else if (v !== 1'b1) begin
                        bad = 1'b1;
                    end
                end
                if (abort) begin
                    $display("[%0d] dut%0d frame aborted by reset", cyc, w + 1);
                end else begin
                    check($sformatf("frame_shape%0d", w + 1), int'(bad), 0);
                    if ((w == 0 && exp1_q.size() == 0) || (w == 1 && exp2_q.size() == 0)) begin
                        check($sformatf("frame_unexpected%0d", w + 1), int'(data), -1);
                    end else begin
                        e = (w == 0) ? exp1_q.pop_front() : exp2_q.pop_front();
                        check($sformatf("frame_data%0d", w + 1), int'(data), int'(e));
                        $display("[%0d] dut%0d frame 0x%02h expected 0x%02h", cyc, w + 1, data, e);
                    end
                end
            end
        end
    endtask

    initial monitor(0);
    initial monitor(1);

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nb;
        int k;
        int c;
        int n0;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_tx", tx1, 1);
        check("rst_busy", busy1, 0);
        check("rst_full", full1, 0);
        check("rst_empty", empty1, 1);
        check("rst_count", count1, 0);
        check("rst_overflow", overflow1, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 1: single 0x55 frame, latency and busy length
        wr(0, 8'h55, 1'b1);
        k = last_wr_cyc;
        check("t1_count_after_write", count1, 1);
        check("t1_empty_after_write", empty1, 0);
        run_until_idle(0, 200, nb);
        check("t1_busy_cycles", nb, 80);
        check("t1_start_latency", starts_q[$], k + 1);

        // 2: three back-to-back frames
        wr(0, 8'h00, 1'b1);
        wr(0, 8'hFF, 1'b1);
        wr(0, 8'hA5, 1'b1);
        check("t2_count_after_writes", count1, 2);
        run_until_idle(0, 400, nb);
        check("t2_gap_1_2", starts_q[starts_q.size()-2] - starts_q[starts_q.size()-3], 80);
        check("t2_gap_2_3", starts_q[starts_q.size()-1] - starts_q[starts_q.size()-2], 80);
        check("t2_count_end", count1, 0);

        // 3: fill while blocked, overflow on 17th, then drain
        cts_n1 = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 16; i++) wr(0, 8'(i), 1'b1);
        check("t3_full", full1, 1);
        check("t3_count16", count1, 16);
        check("t3_no_overflow_yet", overflow1, 0);
        wr(0, 8'h10, 1'b0);
        check("t3_overflow_pulse", overflow1, 1);
        check("t3_count_after_drop", count1, 16);
        @(negedge clk);
        check("t3_overflow_one_cycle", overflow1, 0);
        cts_n1 = 1'b0;
        run_until_idle(0, 1500, nb);
        check("t3_drain_busy_cycles", nb, 1280);
        check("t3_queue_drained", exp1_q.size(), 0);

        // 4: cts deasserted mid-frame; frame completes, then holds
        wr(0, 8'h3C, 1'b1);
        wr(0, 8'h81, 1'b1);
        wr(0, 8'h7E, 1'b1);
        repeat (31) @(negedge clk);
        cts_n1 = 1'b1;
        for (int i = 0; i < 200 && busy1; i++) @(negedge clk);
        check("t4_stopped_busy", busy1, 0);
        check("t4_held_count", count1, 2);
        repeat (10) @(negedge clk);
        check("t4_still_held", int'(busy1) * 100 + int'(count1) + int'(!tx1) * 1000, 2);
        c = cyc;
        cts_n1 = 1'b0;
        run_until_idle(0, 400, nb);
        check("t4_resume_latency", starts_q[starts_q.size()-2], c + 3);
        check("t4_busy_cycles", nb, 160);

        // 5: reset mid-frame flushes FIFO and aborts frame
        n0 = starts_q.size();
        for (int i = 0; i < 5; i++) wr(0, 8'hF0 + 8'(i), 1'b1);
        check("t5_queued", count1, 4);
        repeat (46) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_tx", tx1, 1);
        check("t5_rst_busy", busy1, 0);
        check("t5_rst_empty", empty1, 1);
        check("t5_rst_count", count1, 0);
        exp1_q.delete();
        rst = 1'b0;
        repeat (200) @(negedge clk);
        check("t5_no_more_frames", starts_q.size(), n0 + 1);
        check("t5_line_idle", tx1, 1);

        // 6: two stop bits
        wr(1, 8'hC3, 1'b1);
        run_until_idle(1, 300, nb);
        check("t6_busy_cycles", nb, 88);
        check("t6_queue_drained", exp2_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
